fsk_rx_param: RTL and testbench
===============================

FSK_RX_PARAM -- requirements
Module: fsk_rx_param

Interface
REQ-001 Parameter WIDTH, default 12: number of bits per received word.
REQ-002 Parameter BIT_CYCLES, default 64: clk cycles per bit window, legal range 2 or more.
REQ-003 Parameter THRESH, default 3: a window with more than THRESH rising edges decodes as bit 1, otherwise bit 0.
REQ-004 Parameter CNT_W, default 6: width of the saturating edge counter.
REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  receive enable.
REQ-008 datain  in  1  FSK waveform, asynchronous to clk.
REQ-009 dout_ready  in  1  consumer accepts dataout.
REQ-010 ovr_clr  in  1  clears the overrun flag.
REQ-011 dataout  out  WIDTH  last completed word, bit 0 received first.
REQ-012 dout_valid  out  1  dataout holds an unconsumed word.
REQ-013 overrun  out  1  sticky flag: a completed word was dropped.
REQ-014 carrier  out  1  high while the state is RUN.

Function
REQ-015 datain SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected on the synchronized signal (current high, previous low).
REQ-016 The edge event SHALL reach the counter 3 clk cycles after the datain transition.
REQ-017 States SHALL be IDLE and RUN.
REQ-018 IDLE behaviour: window counter = 0, edge count = 0, bit index = 0.
REQ-019 IDLE to RUN: a detected edge with en=1 SHALL move to RUN, with window counter = 0 and edge count = 1.
REQ-020 RUN window counter: SHALL increment each cycle, from 0 to BIT_CYCLES-1, then wrap to 0.
REQ-021 RUN edge count: SHALL add 1 per detected edge and saturate at 2^CNT_W-1.
REQ-022 Window end (window counter = BIT_CYCLES-1): total = edge count plus any edge detected in that same cycle.
REQ-023 At window end, bit = (total > THRESH); the bit SHALL be written to the word-assembly register at the current bit index, and the edge count SHALL reset to 0.
REQ-024 Carrier loss: if total = 0 at window end, the partial word SHALL be discarded, the bit index SHALL return to 0, and the state SHALL go to IDLE with no bit written.
REQ-025 Word completion: when the bit index is WIDTH-1 at window end, the bit index SHALL wrap to 0 and the word is complete, with RUN continuing.
REQ-026 On completion with dout_valid=0, the assembled word SHALL load into dataout and dout_valid SHALL rise on the next cycle edge; latency is 1 clk from the final window end.
REQ-027 Transfer SHALL occur when dout_valid=1 and dout_ready=1; dout_valid SHALL clear unless a new word completes in the same cycle.
REQ-028 Completion in the same cycle as a transfer: the new word SHALL load, dout_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-029 Completion while dout_valid=1 without a transfer: the new word SHALL be dropped, dataout SHALL keep the old word, and overrun SHALL set.
REQ-030 overrun SHALL clear on ovr_clr=1; when set and clear coincide, set SHALL win.
REQ-031 en=0 SHALL synchronously force IDLE and discard the partial word; dataout, dout_valid and overrun SHALL be unaffected, and handshakes SHALL continue.
REQ-032 dataout SHALL be stable while dout_valid=1.

Reset
REQ-033 reset=0 SHALL asynchronously set: state IDLE, all counters 0, synchronizer flops 0, dataout 0, dout_valid 0, overrun 0, carrier 0.
REQ-034 reset asserted mid-word SHALL discard all partial data; after release, reception SHALL restart only from a fresh edge in IDLE.

Verification (WIDTH=12, BIT_CYCLES=64, THRESH=3)
REQ-035 Word decode: 6 edges per window for a 1, 2 edges per window for a 0, sending 0xA5C LSB first, dout_ready=1 -> dataout=0xA5C, dout_valid high for 1 cycle, 1 clk after the 12th window end.
REQ-036 Threshold boundary: windows with exactly 3 edges and exactly 4 edges -> bits 0 and 1 respectively.
REQ-037 Overrun: two words 0x123 then 0x456 with dout_ready=0 -> dataout=0x123, overrun=1; then ovr_clr pulse -> overrun=0.
REQ-038 Back-to-back completion: dout_ready pulsed in the same cycle as the second word completes -> dataout=0x456, dout_valid stays 1, overrun=0.
REQ-039 Carrier loss: an edge-free window after 5 bits -> carrier=0, no dout_valid; the next 12 bits -> correct word.
REQ-040 Reset mid-word: reset=0 for 2 cycles after bit 7 -> all outputs 0; a subsequent full word decodes correctly.

Source files
------------

// File: rtl/fsk_rx_param.sv
// FSK bit-window receiver: counts synchronized rising edges per window, decodes
// each window to one bit, assembles LSB-first words and hands them off with valid/ready.
module fsk_rx_param #(
   parameter int WIDTH      = 12,
   parameter int BIT_CYCLES = 64,
   parameter int THRESH     = 3,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             datain,
   input  logic             dout_ready,
   input  logic             ovr_clr,
   output logic [WIDTH-1:0] dataout,
   output logic             dout_valid,
   output logic             overrun,
   output logic             carrier
);

   localparam int WIN_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic              sync_p0, sync_p1, sync_p2;
   logic              rise_p2;
   logic [WIN_W-1:0]  win_q, win_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0]  word_q, word_d;
   logic [CNT_W:0]    total;
   logic              done;
   logic              xfer;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic inc);
      if (inc && (cnt != CNT_MAX))
         return cnt + CNT_W'(1);
      return cnt;
   endfunction

   function automatic logic over_thresh(input logic [CNT_W:0] tot);
      return int'(tot) > THRESH;
   endfunction

   // stage p0/p1: metastability synchronizer, p2: previous sample for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= datain;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign rise_p2 = sync_p1 & ~sync_p2;

   // stage p3: window/edge/bit-index state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      done    = 1'b0;
      // An edge landing on the final window cycle still belongs to this window
      total   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rise_p2};
      case (state_q)
         IDLE: begin
            win_d = '0;
            cnt_d = '0;
            idx_d = '0;
            if (en && rise_p2) begin
               state_d = RUN;
               cnt_d   = CNT_W'(1);
            end
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               win_d   = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (win_q == WIN_LAST) begin
               win_d = '0;
               cnt_d = '0;
               if (total == '0) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  word_d[idx_q] = over_thresh(total);
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
                     done  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end else begin
               win_d = win_q + WIN_W'(1);
               cnt_d = sat_inc(cnt_q, rise_p2);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign xfer    = dout_valid & dout_ready;
   assign carrier = (state_q == RUN);

   // stage p4: output word register and handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout    <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (done && (!dout_valid || xfer)) begin
            dataout    <= word_d;
            dout_valid <= 1'b1;
         end else if (xfer) begin
            dout_valid <= 1'b0;
         end
         if (done && dout_valid && !xfer)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fsk_rx_param.sv
// Directed bench for fsk_rx_param: decode, threshold, handshake, carrier loss, reset and enable.
module tb_fsk_rx_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        datain;
   logic        dout_ready;
   logic        ovr_clr;
   logic [11:0] dataout;
   logic        dout_valid;
   logic        overrun;
   logic        carrier;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fsk_rx_param #(
      .WIDTH(12), .BIT_CYCLES(64), .THRESH(3), .CNT_W(6)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .datain(datain),
      .dout_ready(dout_ready), .ovr_clr(ovr_clr), .dataout(dataout),
      .dout_valid(dout_valid), .overrun(overrun), .carrier(carrier)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tail(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         datain = 1'b0;
      end
   endtask

   // m pulses rising at offsets 4+8j; lead adds a pulse at offset 0, which is
   // the start trigger on a fresh word, otherwise the previous window's last-cycle edge
   task automatic send_window(input int m, input bit lead);
      for (int o = 0; o < 64; o++) begin
         tick();
         datain = 1'b0;
         if (lead && (o == 0 || o == 1)) datain = 1'b1;
         for (int j = 0; j < m; j++)
            if (o == 4 + 8 * j || o == 5 + 8 * j) datain = 1'b1;
      end
   endtask

   task automatic send_word(input logic [11:0] w, input bit fresh, input int n1, input int n0);
      for (int k = 0; k < 12; k++) begin
         int n;
         n = w[k] ? n1 : n0;
         if (k == 0 && fresh) send_window(n - 1, 1'b1);
         else                 send_window(n, 1'b0);
      end
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tail(4);
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++; if (dataout !== 12'h000) begin errors++; $display("FAIL reset_dataout got %h want 000", dataout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL reset_carrier got %b want 0", carrier); end
      tick();
      tick();
      reset = 1'b1;
      tail(4);
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL reset_idle_carrier got %b want 0", carrier); end
   endtask

   task automatic test_decode();
      do_reset();
      dout_ready = 1'b1;
      send_word(12'hA5C, 1'b1, 6, 2);
      tail(3);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL decode_early_valid got %b want 0", dout_valid); end
      checks++; if (carrier !== 1'b1) begin errors++; $display("FAIL decode_carrier got %b want 1", carrier); end
      tail(1);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL decode_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'hA5C) begin errors++; $display("FAIL decode_dataout got %h want a5c", dataout); end
      tail(1);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL decode_valid_pulse got %b want 0", dout_valid); end
      tail(63);
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL decode_loss_idle got %b want 0", carrier); end
   endtask

   task automatic test_threshold();
      int leads [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      int ms    [12] = '{2, 4, 3, 3, 3, 4, 3, 4, 3, 4, 4, 3};
      do_reset();
      dout_ready = 1'b1;
      for (int k = 0; k < 12; k++) send_window(ms[k], leads[k] != 0);
      tail(4);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL thresh_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'h6A6) begin errors++; $display("FAIL thresh_dataout got %h want 6a6", dataout); end
   endtask

   task automatic test_overrun();
      do_reset();
      dout_ready = 1'b0;
      send_word(12'h123, 1'b1, 6, 2);
      send_word(12'h456, 1'b0, 6, 2);
      tail(4);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'h123) begin errors++; $display("FAIL ovr_dataout got %h want 123", dataout); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
      tail(1);
      ovr_clr = 1'b1;
      tail(1);
      ovr_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", overrun); end
      checks++; if (dataout !== 12'h123) begin errors++; $display("FAIL ovr_stable got %h want 123", dataout); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dout_ready = 1'b0;
      send_word(12'h123, 1'b1, 6, 2);
      send_word(12'h456, 1'b0, 6, 2);
      tail(2);
      checks++; if (dataout !== 12'h123) begin errors++; $display("FAIL b2b_first got %h want 123", dataout); end
      tail(1);
      dout_ready = 1'b1;
      tail(1);
      dout_ready = 1'b0;
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'h456) begin errors++; $display("FAIL b2b_dataout got %h want 456", dataout); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
   endtask

   task automatic test_carrier_loss();
      logic [4:0] part;
      part = 5'b10110;
      do_reset();
      dout_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) send_window((part[k] ? 6 : 2) - 1, 1'b1);
         else        send_window(part[k] ? 6 : 2, 1'b0);
      end
      send_window(0, 1'b0);
      tail(2);
      checks++; if (carrier !== 1'b1) begin errors++; $display("FAIL loss_pre_carrier got %b want 1", carrier); end
      tail(2);
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL loss_carrier got %b want 0", carrier); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL loss_valid got %b want 0", dout_valid); end
      send_word(12'h3C9, 1'b1, 6, 2);
      tail(4);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL loss_word_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'h3C9) begin errors++; $display("FAIL loss_word_dataout got %h want 3c9", dataout); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dout_ready = 1'b0;
      send_word(12'h5A5, 1'b1, 6, 2);
      for (int k = 0; k < 7; k++) send_window(6, 1'b0);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", dout_valid); end
      reset = 1'b0;
      #1;
      checks++; if (dataout !== 12'h000) begin errors++; $display("FAIL rmid_dataout got %h want 000", dataout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", dout_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", overrun); end
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL rmid_carrier got %b want 0", carrier); end
      tick();
      tick();
      reset = 1'b1;
      tail(4);
      dout_ready = 1'b1;
      send_word(12'h9E1, 1'b1, 6, 2);
      tail(4);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_word_valid got %b want 1", dout_valid); end
      checks++; if (dataout !== 12'h9E1) begin errors++; $display("FAIL rmid_word_dataout got %h want 9e1", dataout); end
   endtask

   task automatic test_enable();
      do_reset();
      dout_ready = 1'b1;
      send_window(5, 1'b1);
      send_window(2, 1'b0);
      send_window(6, 1'b0);
      tail(1);
      en = 1'b0;
      tail(1);
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL en_carrier got %b want 0", carrier); end
      en = 1'b1;
      tail(4);
      checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL en_stay_idle got %b want 0", carrier); end
      send_word(12'h7E2, 1'b1, 6, 2);
      tail(3);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL en_early_valid got %b want 0", dout_valid); end
      tail(1);
      checks++; if (dataout !== 12'h7E2) begin errors++; $display("FAIL en_word_dataout got %h want 7e2", dataout); end
   endtask

   initial begin
      reset      = 1'b1;
      en         = 1'b1;
      datain     = 1'b0;
      dout_ready = 1'b0;
      ovr_clr    = 1'b0;
      test_reset();
      test_decode();
      test_threshold();
      test_overrun();
      test_back_to_back();
      test_carrier_loss();
      test_reset_mid();
      test_enable();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
